fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer depth and maximum outstanding-plus-buffered credit.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port arst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req  out  1  fetch request valid.
REQ-006 SHALL have port imem_addr  out  64  fetch address, equal to the current PC.
REQ-007 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata  in  32  response instruction word.
REQ-010 SHALL have port redirect  in  1  branch/jump flush request.
REQ-011 SHALL have port redirect_pc  in  64  new fetch target.
REQ-012 SHALL have port stall  in  1  hazard hold from the IF/ID register.
REQ-013 SHALL have port out_valid  out  1  out_inst/out_pc hold a valid fetched instruction.
REQ-014 SHALL have port out_inst  out  32  instruction to IF/ID.
REQ-015 SHALL have port out_pc  out  64  PC of out_inst.

Function
REQ-016 SHALL hold the PC in a 64-bit register; a grant (imem_req && imem_gnt) advances PC by 4, modulo 2^64 (wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0).
REQ-017 SHALL assert imem_req only when (outstanding + buffered) < FIFO_DEPTH and redirect is low.
REQ-018 SHALL record the PC of each granted request in an in-order pending queue; each non-dropped imem_rvalid pairs imem_rdata with the oldest pending PC and pushes {pc, inst} into the instruction FIFO.
REQ-019 SHALL drive out_valid high exactly when the FIFO is non-empty and redirect is low; out_inst/out_pc show the FIFO head.
REQ-020 SHALL drive out_inst = 32'h0000_0013 (NOP) and out_pc = 0 whenever out_valid is low.
REQ-021 SHALL pop the FIFO head when out_valid && !stall; stall holds head and contents unchanged.
REQ-022 SHALL allow a push and a pop in the same cycle at any occupancy, including full; occupancy then stays constant.
REQ-023 SHALL never overflow: the credit rule of REQ-017 guarantees space for every outstanding response.
REQ-024 On redirect SHALL, in the same edge: load PC with {redirect_pc[63:2], 2'b00}, empty the FIFO and pending queue, and load a drop counter with the current outstanding count.
REQ-025 SHALL discard (not push) imem_rvalid responses while the drop counter is non-zero, decrementing it per response; a response arriving in the redirect cycle itself is discarded and counted.
REQ-026 SHALL give redirect priority over stall, grant and push; a grant coinciding with redirect cannot occur (REQ-017).
REQ-027 SHALL resume requesting from the redirect target the cycle after redirect, subject to REQ-017 with dropped responses still counted as outstanding.
REQ-028 SHALL have fetch latency of 2 cycles minimum: grant at cycle N, rvalid at N+1, out_valid at N+2.

Reset
REQ-029 While arst is high SHALL force PC = RESET_PC, FIFO and pending queue empty, drop counter 0, imem_req 0, out_valid 0, out_inst NOP, out_pc 0.
REQ-030 Reset asserted mid-operation SHALL abandon all outstanding requests; responses returning after reset release are not tracked and SHALL be ignored until the first post-reset grant.
REQ-031 SHALL issue the first request on the first clk edge after arst falls.

Structure
REQ-032 Shared package fetch_pkg SHALL hold XLEN=64, ILEN=32, NOP_INST=32'h0000_0013 and the {pc, inst} entry type.
REQ-033 SHALL instantiate one sub-module, fetch_fifo: parameterised synchronous FIFO with push, pop, full, empty, count, clear.

Verification
REQ-034 Reset release, RESET_PC=0x1000, gnt tied 1, 1-cycle rvalid, stall 0 -> out_pc sequence 0x1000, 0x1004, 0x1008 on consecutive cycles from cycle 2.
REQ-035 Stall held 5 cycles with FIFO full -> imem_req low, out_pc constant, no instruction lost or duplicated after release.
REQ-036 Redirect to 0x2002 with 2 responses outstanding -> both responses dropped, next out_pc 0x2000, no stale PC ever valid.
REQ-037 PC at 0xFFFF_FFFF_FFFF_FFFC granted -> next imem_addr 0x0.
REQ-038 Push and pop same cycle at full, gnt random 50% -> occupancy stable, in-order delivery versus reference model.
REQ-039 arst pulsed with 2 outstanding -> outputs reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, the NOP encoding and the buffered {pc, inst} entry type
// used by the fetch unit and its instruction buffer.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a combinational head, same-cycle push/pop at any
// occupancy, and a flush input that wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees its slot on the same edge, so a push while full is still legal.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order pairing
// of responses with their PCs, flush/drop on redirect, buffered IF/ID output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            arst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [XLEN-1:0]    r_pc;
  logic [CW-1:0]      r_outst;
  logic [CW-1:0]      r_drop;
  logic [XLEN-1:0]    r_pend_pc [FIFO_DEPTH];
  logic [PW-1:0]      r_pend_wr;
  logic [PW-1:0]      r_pend_rd;

  logic               w_grant;
  logic               w_rsp;
  logic               w_rsp_keep;
  logic               w_credit;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [CW-1:0]      w_count;
  logic [ENTRY_W-1:0] w_head_bits;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Dropped responses stay in r_outst, so they keep consuming credit.
  assign w_credit   = !w_full && ((32'(r_outst) + 32'(w_count)) < 32'(FIFO_DEPTH));
  assign imem_req   = !arst && !redirect && w_credit;
  assign imem_addr  = r_pc;
  assign w_grant    = imem_req && imem_gnt;
  // A response with nothing outstanding belongs to a request abandoned by reset.
  assign w_rsp      = imem_rvalid && (r_outst != '0);
  assign w_rsp_keep = w_rsp && (r_drop == '0) && !redirect;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_drop    <= '0;
      r_pend_wr <= '0;
      r_pend_rd <= '0;
    end else if (redirect) begin
      r_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
      r_outst   <= r_outst - CW'(w_rsp);
      r_drop    <= r_outst - CW'(w_rsp);
      r_pend_wr <= '0;
      r_pend_rd <= '0;
    end else begin
      if (w_grant) begin
        r_pc      <= r_pc + 64'd4;
        r_pend_wr <= ptr_inc(r_pend_wr);
      end
      if (w_rsp_keep) r_pend_rd <= ptr_inc(r_pend_rd);
      if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_pend_pc[r_pend_wr] <= r_pc;
  end

  assign w_push_entry = '{pc: r_pend_pc[r_pend_rd], inst: imem_rdata};
  assign w_pop        = out_valid && !stall;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .i_push  (w_rsp_keep),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .i_wdata (w_push_entry),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head    = fetch_entry_t'(w_head_bits);
  assign out_valid = !w_empty && !redirect;
  assign out_inst  = out_valid ? w_head.inst : NOP_INST;
  assign out_pc    = out_valid ? w_head.pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, PC wrap,
// mid-run reset and a random-grant in-order delivery run.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        arst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] rq[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (64'h1000),
    .FIFO_DEPTH (3)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: note a grant in the current cycle, then drive the next cycle's
  // inputs; responses come back in order from rq when ren is set.
  task automatic cyc(input logic gnt, input logic ren, input logic stl,
                     input logic rdr, input logic [63:0] rpc);
    if (imem_req && imem_gnt) rq.push_back(imem_addr);
    @(posedge clk);
    #1;
    imem_gnt    = gnt;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    if (ren && rq.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(rq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
  endtask

  initial begin
    logic [63:0] exp_pc;
    int          delivered;
    logic        g, s, r;

    arst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 64'h0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req",   64'(imem_req),  64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_inst",  64'(out_inst),  64'h13);
    chk("rst_pc",    out_pc,         64'h0);
    chk("rst_addr",  imem_addr,      64'h1000);

    // Streaming after reset release.
    @(posedge clk); #1; arst = 1'b0; #1;
    chk("c0_req",  64'(imem_req), 64'h1);
    chk("c0_addr", imem_addr,     64'h1000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("c1_valid", 64'(out_valid), 64'h0);
    chk("c1_addr",  imem_addr,      64'h1004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("c2_pc",   out_pc,         64'h1000);
    chk("c2_inst", 64'(out_inst),  64'(inst_of(64'h1000)));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("c3_pc",   out_pc,         64'h1004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("c4_pc",   out_pc,         64'h1008);

    // Stall for 5 cycles until the buffer fills.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("stall_c5_pc", out_pc, 64'h100c);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("stall_c6_req", 64'(imem_req), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
      chk("stall_full_req",   64'(imem_req),  64'h0);
      chk("stall_full_valid", 64'(out_valid), 64'h1);
      chk("stall_full_pc",    out_pc,         64'h100c);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      chk("release_pc", out_pc, 64'h100c + 64'(4 * i));
    end

    // Two requests outstanding, then redirect to a misaligned target.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("c15_pc", out_pc, 64'h1020);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    chk("c16_pc",   out_pc,    64'h1024);
    chk("c16_addr", imem_addr, 64'h1028);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    chk("c17_addr", imem_addr, 64'h102c);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    chk("credit_req", 64'(imem_req), 64'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'h2002);
    chk("rdr_valid", 64'(out_valid), 64'h0);
    chk("rdr_pc",    out_pc,         64'h0);
    chk("rdr_inst",  64'(out_inst),  64'h13);
    chk("rdr_req",   64'(imem_req),  64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("rdr1_req",   64'(imem_req),  64'h1);
    chk("rdr1_addr",  imem_addr,      64'h2000);
    chk("rdr1_valid", 64'(out_valid), 64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("drop_valid", 64'(out_valid), 64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("rdr_first_pc",   out_pc,        64'h2000);
    chk("rdr_first_inst", 64'(out_inst), 64'(inst_of(64'h2000)));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("rdr_second_pc",  out_pc,        64'h2004);

    // PC wrap at the top of the address space.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_rdr_valid", 64'(out_valid), 64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_req",  64'(imem_req), 64'h1);
    chk("wrap_addr", imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_next_addr", imem_addr, 64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_out_pc",   out_pc,        64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_out_inst", 64'(out_inst), 64'h3501_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_zero_pc",   out_pc,        64'h0);
    chk("wrap_zero_inst", 64'(out_inst), 64'hCAFE_0000);

    // Reset pulse with two responses still in flight.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("pre_arst_outstanding", 64'(rq.size()), 64'h2);
    arst = 1'b1;
    #1;
    chk("arst_req",   64'(imem_req),  64'h0);
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_pc",    out_pc,         64'h0);
    chk("arst_inst",  64'(out_inst),  64'h13);
    chk("arst_addr",  imem_addr,      64'h1000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("arst_hold_valid", 64'(out_valid), 64'h0);
    chk("arst_hold_req",   64'(imem_req),  64'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    arst = 1'b0;
    #1;
    chk("restart_req",  64'(imem_req), 64'h1);
    chk("restart_addr", imem_addr,     64'h1000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("stale_ignored", 64'(out_valid), 64'h0);
    chk("restart_addr2", imem_addr,      64'h1004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("restart_pc",   out_pc,        64'h1000);
    chk("restart_inst", 64'(out_inst), 64'(inst_of(64'h1000)));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("restart_pc2",  out_pc,        64'h1004);

    // Random grant, stall and response timing; delivery must stay in order.
    exp_pc    = 64'h1008;
    delivered = 0;
    for (int i = 0; i < 400; i++) begin
      g = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(g, r, s, 1'b0, 64'h0);
      if (out_valid && !stall) begin
        chk("seq_pc",   out_pc,        exp_pc);
        chk("seq_inst", 64'(out_inst), 64'(inst_of(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
    end
    chk("seq_progress", 64'(delivered >= 40), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
